// File: rtl/fifo_bank_ctrl_if.sv
// Push/pop stream and bank command bundle for fifo_bank_ctrl.
// master = controller side, slave = producer/consumer/bank side.
interface fifo_bank_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  level;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, level,
               mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, level,
               mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );
endinterface

// File: rtl/fifo_bank_ctrl.sv
// FIFO controller driving a 1-cycle-latency single-port bank plus a 2-entry output buffer.
// Optional macro FIFO_CTRL_BYPASS_EN: pushes into an empty FIFO skip the bank.
module fifo_bank_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 3)
) (
    input logic              clk,
    input logic              rst,
    fifo_bank_ctrl_if.master bus
);
    localparam int unsigned BCW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [BCW-1:0]        r_bank_cnt;
    logic [BCW-1:0]        r_avail_cnt;
    logic [1:0]            r_obuf_cnt;
    logic                  r_obuf_head;
    logic [DATA_WIDTH-1:0] r_obuf [2];
    logic                  r_inflight;
    logic                  r_pend_commit;
    logic                  r_port_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_ren;
    logic                  w_bypass;
    logic                  w_bank_wr;
    logic                  w_obuf_we;
    logic                  w_obuf_tail;
    logic [DATA_WIDTH-1:0] w_obuf_wdata;

    assign bus.in_ready = (r_bank_cnt < BCW'(FIFO_DEPTH)) & ~rst;
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = (r_obuf_cnt != 2'd0) & bus.out_ready;

    // Reads are only issued when the buffer is guaranteed room on capture.
    assign w_ren = (r_avail_cnt != '0) & ~r_port_busy
                 & ((r_obuf_cnt + {1'b0, r_inflight} - {1'b0, w_pop}) < 2'd2);

`ifdef FIFO_CTRL_BYPASS_EN
    assign w_bypass = w_push & (r_bank_cnt == '0) & ~r_inflight & ~r_pend_commit
                    & ((r_obuf_cnt - {1'b0, w_pop}) < 2'd2);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bank_wr    = w_push & ~w_bypass;
    assign w_obuf_we    = r_inflight | w_bypass;
    assign w_obuf_tail  = r_obuf_head ^ r_obuf_cnt[0];
    assign w_obuf_wdata = r_inflight ? bus.mem_rdata : bus.in_data;

    assign bus.mem_wen   = w_bank_wr;
    assign bus.mem_waddr = r_wptr;
    assign bus.mem_wdata = bus.in_data;
    assign bus.mem_ren   = w_ren;
    assign bus.mem_raddr = r_rptr;

    assign bus.out_valid = (r_obuf_cnt != 2'd0);
    assign bus.out_data  = r_obuf[r_obuf_head];
    assign bus.level     = CNT_WIDTH'(r_bank_cnt) + CNT_WIDTH'(r_inflight)
                         + CNT_WIDTH'(r_obuf_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_bank_cnt    <= '0;
            r_avail_cnt   <= '0;
            r_obuf_cnt    <= 2'd0;
            r_obuf_head   <= 1'b0;
            r_obuf[0]     <= '0;
            r_obuf[1]     <= '0;
            r_inflight    <= 1'b0;
            r_pend_commit <= 1'b0;
            r_port_busy   <= 1'b0;
        end else begin
            if (w_bank_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_ren) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_bank_cnt <= r_bank_cnt + BCW'(w_bank_wr) - BCW'(w_ren);
            // A write colliding with a read lands a cycle late, so it commits a cycle late.
            r_avail_cnt <= r_avail_cnt + BCW'(w_bank_wr & ~w_ren) + BCW'(r_pend_commit)
                         - BCW'(w_ren);
            r_port_busy   <= w_bank_wr & w_ren;
            r_pend_commit <= w_bank_wr & w_ren;
            r_inflight    <= w_ren;
            if (w_obuf_we) begin
                r_obuf[w_obuf_tail] <= w_obuf_wdata;
            end
            if (w_pop) begin
                r_obuf_head <= ~r_obuf_head;
            end
            r_obuf_cnt <= r_obuf_cnt + {1'b0, w_obuf_we} - {1'b0, w_pop};
        end
    end
endmodule

// File: doc/fifo_bank_ctrl.md
Name: fifo_bank_ctrl

Overview:
- Synchronous FIFO controller that sequences one `fifo_bank` instance: a single-port RAM wrapper with 1-cycle read latency.
- On a same-cycle write+read, the bank defers the write by one cycle.
- The controller converts valid/ready push and pop streams into bank write/read commands and tracks occupancy and commit timing.
- It owns a 2-entry output buffer so `out_data` is a registered, stall-stable stream.
- Sits between a producer and a consumer inside the sync FIFO subsystem.

Parameters:
- DATA_WIDTH, 8, payload width.
- FIFO_DEPTH, 16, bank entries; power of 2, at least 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), bank address width.
- CNT_WIDTH, $clog2(FIFO_DEPTH+3), width of the level output.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data; a push occurs when in_valid & in_ready.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer takes the head; a pop occurs when out_valid & out_ready.
- out_data  out  DATA_WIDTH  head payload, registered.
- level  out  CNT_WIDTH  total entries held: bank + in-flight + output buffer.
- mem_wen  out  1  to bank wen.
- mem_waddr  out  ADDR_WIDTH  to bank waddr.
- mem_wdata  out  DATA_WIDTH  to bank wdata.
- mem_ren  out  1  to bank ren.
- mem_raddr  out  ADDR_WIDTH  to bank raddr.
- mem_rdata  in  DATA_WIDTH  from bank rdata; valid the cycle after mem_ren.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (at the first edge with rst=1), all held while rst=1:
  - wptr = rptr = 0, bank_cnt = 0, avail_cnt = 0.
  - obuf_cnt = 0, inflight = 0, pend_commit = 0, port_busy = 0.
  - out_valid = 0, out_data = 0, level = 0.
  - mem_wen = mem_ren = 0.
  - in_ready = 0 while rst=1; in_ready = 1 on the first cycle after deassertion.
- Write path:
  - in_ready = (bank_cnt < FIFO_DEPTH) & ~rst.
  - On a push: mem_wen=1, mem_waddr=wptr, mem_wdata=in_data; wptr increments modulo FIFO_DEPTH (wraps 15->0 at default); bank_cnt increments.
- Commit tracking: a bank entry becomes readable only once it is physically written.
  - Push without mem_ren in cycle T: avail_cnt increments at the end of T.
  - Push with mem_ren in cycle T (collision): the bank writes in T+1. Set port_busy=1 and pend_commit=1 for T+1; avail_cnt increments at the end of T+1.
- Read path: mem_ren=1, mem_raddr=rptr when all of the following hold:
  - avail_cnt > 0;
  - port_busy = 0;
  - obuf_cnt + inflight - (pop this cycle) < 2.
  - On issue: rptr increments modulo FIFO_DEPTH; bank_cnt and avail_cnt decrement; inflight=1 for the next cycle.
- Never issue mem_ren while port_busy=1. The bank address is owned by the deferred write in that cycle.
- Output buffer: 2-entry register FIFO.
  - mem_rdata is captured at the end of the cycle in which inflight=1.
  - out_data = head entry. It must stay stable while out_valid & ~out_ready.
  - out_valid = (obuf_cnt > 0).
- Latency without bypass, push in cycle T, FIFO empty, out_ready=1:
  - mem_ren in T+1.
  - out_valid in T+3.
  - With a collision in T: earliest mem_ren for that entry is T+2.
- Simultaneous push and pop:
  - Allowed in any state; level is unchanged.
  - Full: push is blocked by in_ready even if a pop occurs in the same cycle. No combinational in_ready->out_ready path.
- Capacity: FIFO_DEPTH+2 entries (18 at default).
- Order: strict FIFO order; no loss or duplication under any valid/ready pattern.
- Reset mid-operation: all contents discarded. State is as at reset on the next cycle; no stale out_valid.

Optional Feature:
- Macro: FIFO_CTRL_BYPASS_EN.
- Defined:
  - Bypass applies when bank_cnt=0, inflight=0, pend_commit=0 and the output buffer has room after this cycle's pop.
  - Under those conditions a push is written directly into the output buffer; mem_wen stays 0.
  - Empty-FIFO latency: out_valid in T+1.
- Undefined: every push goes through the bank; latency as above.

Test Plan:
- Reset, then push 0xA5 with out_ready=1 (no macro) -> mem_wen in T with waddr=0; mem_ren in T+1 with raddr=0; out_valid=1 and out_data=0xA5 in T+3; level returns to 0.
- out_ready=0, push 0x00..0x11 back-to-back -> 18 pushes accepted; in_ready=0 afterwards; level=18; then out_ready=1 drains 0x00..0x11 in order; level=0.
- in_valid=out_ready=1 with an incrementing pattern for 40 cycles -> every collision cycle is followed by mem_ren=0; addresses wrap 15->0; output sequence is exactly the input sequence.
- Fill 5 entries, toggle out_ready every cycle -> out_data constant in every stall cycle; 5 distinct words out in order.
- 6 entries held, assert rst for 1 cycle -> next cycle out_valid=0, level=0, in_ready=1; a following push of 0x77 is returned as first output.
- With FIFO_CTRL_BYPASS_EN, empty FIFO, push 0x3C -> out_valid=1 and out_data=0x3C in T+1; mem_wen never asserted.
